// File: rtl/pc_ctrl_pkg.sv
// Shared pipeline definitions for next-PC selection and fetch control.
// Pure declarations: no latency.
// No flow control of its own.
package pc_ctrl_pkg;

  // Redirect modes presented by the D stage
  localparam logic [1:0] NPC_SEQ = 2'b00;  // sequential fetch
  localparam logic [1:0] NPC_BR  = 2'b01;  // PC-relative branch
  localparam logic [1:0] NPC_REG = 2'b10;  // register-indirect jump
  localparam logic [1:0] NPC_J   = 2'b11;  // 26-bit region jump

  // Default fetch-address constants
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

  // Fetch controller states: RUN = normal, PEND = redirect buffered behind a stall
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } pc_state_e;

  // Sign-extended, word-scaled branch displacement
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/npc_target.sv
// Redirect target calculation from the D-stage instruction fields.
// Latency: purely combinational.
// No backpressure; the result is only consumed when npc_sel is non-sequential.
module npc_target
  import pc_ctrl_pkg::*;
(
  input  logic [1:0]  npc_sel,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] reg_target,
  input  logic [31:0] pc4_d,
  output logic [31:0] target
);

  // Select the redirect address; sums wrap modulo 2^32
  always_comb begin
    target = pc4_d;
    case (npc_sel)
      NPC_BR:  target = pc4_d + br_offset(imm16);
      NPC_REG: target = reg_target;
      NPC_J:   target = {pc4_d[31:28], imm26, 2'b00};
      default: target = pc4_d;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch PC register with redirect buffering while F/D is stalled.
// Latency: redirects, exceptions and eret take effect on the next rising edge.
// Stall holds pc_f; a redirect seen during stall is buffered and applied on release.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC    = DEF_EXC_VEC,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] reg_target,
  input  logic [31:0] pc4_d,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_f,
  output logic [31:0] pc4_f,
  output logic        redir_pending,
  output logic        adel_f
);

  // One past the last legal fetch byte; 33 bits so the bound cannot wrap
  localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) << 2);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] target;
  logic        redirect;

  npc_target u_npc_target (
    .npc_sel    (npc_sel),
    .imm16      (imm16),
    .imm26      (imm26),
    .reg_target (reg_target),
    .pc4_d      (pc4_d),
    .target     (target)
  );

  assign redirect = (npc_sel != NPC_SEQ);

  // Next-PC priority: exception > eret > buffered/new redirect > stall hold > sequential
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    if (exc_req) begin
      pc_d    = EXC_VEC;
      pend_d  = '0;
      state_d = ST_RUN;
    end else if (eret_req) begin
      pc_d    = epc;
      pend_d  = '0;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (redirect) begin
            if (stall) begin
              pend_d  = target;
              state_d = ST_PEND;
            end else begin
              pc_d = target;
            end
          end else if (!stall) begin
            pc_d = pc_q + 32'd4;
          end
        end
        ST_PEND: begin
          if (stall) begin
            // Newest redirect replaces the buffered one
            if (redirect) pend_d = target;
          end else begin
            // Buffered redirect wins over anything presented on release
            pc_d    = pend_q;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State, fetch PC and pending-target registers with async reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  // Fetch-side outputs; misaligned or out-of-range addresses are flagged, not corrected
  always_comb begin
    pc_f          = pc_q;
    pc4_f         = pc_q + 32'd4;
    redir_pending = (state_q == ST_PEND);
    adel_f        = (pc_q[1:0] != 2'b00) ||
                    (pc_q < IMEM_BASE) ||
                    ({1'b0, pc_q} >= IMEM_END);
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus random traffic.
// Expected values come from a cycle-level behavioural model of the fetch rules.
// Bench drives stall directly; no other flow control.
module tb_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;
  localparam longint      MEM_LO = 64'h3000;
  localparam longint      MEM_HI = 64'h3000 + 4 * 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic [15:0] imm16 = '0;
  logic [25:0] imm26 = '0;
  logic [31:0] reg_target = '0;
  logic [31:0] pc4_d = '0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = '0;
  logic [31:0] pc_f;
  logic [31:0] pc4_f;
  logic        redir_pending;
  logic        adel_f;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_tgt;

  pc_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .npc_sel       (npc_sel),
    .imm16         (imm16),
    .imm26         (imm26),
    .reg_target    (reg_target),
    .pc4_d         (pc4_d),
    .exc_req       (exc_req),
    .eret_req      (eret_req),
    .epc           (epc),
    .pc_f          (pc_f),
    .pc4_f         (pc4_f),
    .redir_pending (redir_pending),
    .adel_f        (adel_f)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_target();
    longint t;
    case (npc_sel)
      2'b01: t = longint'(pc4_d) + 4 * longint'($signed(imm16));
      2'b10: t = longint'(reg_target);
      default: t = longint'(pc4_d[31:28]) * 64'h1000_0000 + longint'(imm26) * 4;
    endcase
    return t[31:0];
  endfunction

  function automatic logic model_adel();
    longint p = longint'(m_pc);
    return ((p % 4) != 0) || (p < MEM_LO) || (p >= MEM_HI);
  endfunction

  task automatic model_reset();
    m_pc   = RST_PC;
    m_pend = 0;
    m_tgt  = '0;
  endtask

  // One clock of the fetch rules, applied to the inputs present at the edge
  task automatic model_edge();
    longint nxt;
    if (exc_req) begin
      m_pc = EXC_PC; m_pend = 0;
    end else if (eret_req) begin
      m_pc = epc; m_pend = 0;
    end else if (m_pend) begin
      if (!stall) begin
        m_pc = m_tgt; m_pend = 0;
      end else if (npc_sel != 2'b00) begin
        m_tgt = model_target();
      end
    end else if (npc_sel != 2'b00) begin
      if (!stall) m_pc = model_target();
      else begin
        m_pend = 1; m_tgt = model_target();
      end
    end else if (!stall) begin
      nxt  = (longint'(m_pc) + 4) % 64'h1_0000_0000;
      m_pc = nxt[31:0];
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc_f"}, pc_f, m_pc);
    check({tag, ".pc4_f"}, pc4_f, m_pc + 32'd4);
    check({tag, ".pend"}, {31'b0, redir_pending}, {31'b0, m_pend});
    check({tag, ".adel"}, {31'b0, adel_f}, {31'b0, model_adel()});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    stall = 0; npc_sel = 2'b00; exc_req = 0; eret_req = 0;
  endtask

  initial begin
    // Asynchronous reset assertion, before any clock edge
    #1 reset = 1;
    model_reset();
    #1;
    check("rst_pc", pc_f, 32'h3000);
    check("rst_pend", {31'b0, redir_pending}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    #1 check_all("rel");

    // Three idle cycles
    step("idle1"); check("idle1_c", pc_f, 32'h3004);
    step("idle2"); check("idle2_c", pc_f, 32'h3008);
    step("idle3"); check("idle3_c", pc_f, 32'h300C);

    // Backward branch
    npc_sel = 2'b01; pc4_d = 32'h3010; imm16 = 16'hFFFE;
    step("br"); check("br_c", pc_f, 32'h3008);

    // Jump buffered behind a two-cycle stall
    stall = 1; npc_sel = 2'b11; imm26 = 26'h0000C10; pc4_d = 32'h3004;
    step("jst1"); check("jst1_c", pc_f, 32'h3008);
    step("jst2"); check("jst2_c", {31'b0, redir_pending}, 32'd1);
    idle();
    step("jrel"); check("jrel_c", pc_f, 32'h3040);
    check("jrel_p", {31'b0, redir_pending}, 32'd0);

    // Newest redirect wins; redirect presented on release is ignored
    stall = 1; npc_sel = 2'b10; reg_target = 32'h3100;
    step("nw1");
    reg_target = 32'h3200;
    step("nw2");
    stall = 0; reg_target = 32'h3300;
    step("nw3"); check("nw3_c", pc_f, 32'h3200);
    idle();
    step("nw4");

    // Exception in PEND, then eret
    stall = 1; npc_sel = 2'b10; reg_target = 32'h3500;
    step("ex0");
    exc_req = 1;
    step("ex1"); check("ex1_c", pc_f, 32'h4180);
    exc_req = 0; eret_req = 1; epc = 32'h3020; stall = 0; npc_sel = 2'b00;
    step("er1"); check("er1_c", pc_f, 32'h3020);
    idle();

    // Misaligned and out-of-range targets
    npc_sel = 2'b10; reg_target = 32'h3002;
    step("mis"); check("mis_c", {31'b0, adel_f}, 32'd1);
    reg_target = 32'h7000;
    step("oor"); check("oor_c", {31'b0, adel_f}, 32'd1);
    reg_target = 32'h6FFC;
    step("top"); check("top_c", {31'b0, adel_f}, 32'd0);

    // Sequential wrap past the top of the address space
    reg_target = 32'hFFFF_FFFC;
    step("wr0");
    idle();
    step("wr1"); check("wr1_c", pc_f, 32'h0000_0000);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      stall      = ($urandom_range(0, 1) == 1);
      npc_sel    = 2'($urandom_range(0, 3));
      imm16      = 16'($urandom);
      imm26      = 26'($urandom);
      reg_target = $urandom;
      pc4_d      = $urandom;
      exc_req    = ($urandom_range(0, 15) == 0);
      eret_req   = ($urandom_range(0, 15) == 0);
      epc        = $urandom;
      step("rnd");
    end
    idle();

    // Async reset between edges while a redirect is buffered
    stall = 1; npc_sel = 2'b10; reg_target = 32'h3600;
    step("ar0");
    #2 reset = 1;
    model_reset();
    #1;
    check("ar_pc", pc_f, 32'h3000);
    check("ar_pend", {31'b0, redir_pending}, 32'd0);
    idle();
    @(negedge clk);
    reset = 0;
    #1 check_all("ar_rel");
    step("ar1"); check("ar1_c", pc_f, 32'h3004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, meaning fetch address after reset.
REQ-002 Parameter EXC_VEC, default 32'h0000_4180, meaning exception handler entry.
REQ-003 Parameter IMEM_BASE, default 32'h0000_3000, meaning lowest legal fetch address.
REQ-004 Parameter IMEM_WORDS, default 4096, meaning instruction-memory depth in words.
REQ-005 Port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-006 Port reset, input, 1, meaning asynchronous, active-high reset.
REQ-007 Port stall, input, 1, meaning F/D hold request from hazard unit.
REQ-008 Port npc_sel, input, 2, meaning redirect mode: 00 sequential, 01 branch offset, 10 register target, 11 26-bit index.
REQ-009 Port imm16, input, 16, meaning branch offset of D-stage instruction.
REQ-010 Port imm26, input, 26, meaning jump index of D-stage instruction.
REQ-011 Port reg_target, input, 32, meaning forwarded rs value for register jumps.
REQ-012 Port pc4_d, input, 32, meaning PC+4 of D-stage instruction.
REQ-013 Port exc_req, input, 1, meaning exception taken this cycle.
REQ-014 Port eret_req, input, 1, meaning return from exception.
REQ-015 Port epc, input, 32, meaning return address for eret.
REQ-016 Port pc_f, output, 32, meaning current fetch address (register).
REQ-017 Port pc4_f, output, 32, meaning pc_f + 4 (combinational).
REQ-018 Port redir_pending, output, 1, meaning a redirect is buffered awaiting stall release.
REQ-019 Port adel_f, output, 1, meaning fetch address misaligned or outside IMEM.

Function
REQ-020 Target: 01 -> pc4_d + {sext(imm16),2'b00}; 10 -> reg_target; 11 -> {pc4_d[31:28],imm26,2'b00}; all sums modulo 2^32.
REQ-021 Next-PC priority per cycle SHALL be exc_req > eret_req > pending/redirect > hold (stall) > pc_f+4.
REQ-022 exc_req SHALL load EXC_VEC regardless of stall and clear any pending redirect.
REQ-023 eret_req (exc_req low) SHALL load epc regardless of stall and clear any pending redirect.
REQ-024 FSM states RUN and PEND; reset state RUN.
REQ-025 RUN, stall=0, npc_sel!=00: pc_f <= target next edge, stay RUN.
REQ-026 RUN, stall=1, npc_sel!=00: pc_f holds, target captured into pend_reg, go PEND.
REQ-027 RUN, stall=1, npc_sel=00: pc_f holds, stay RUN; stall=0, npc_sel=00: pc_f <= pc_f+4.
REQ-028 PEND, stall=1: pc_f holds; a new npc_sel!=00 overwrites pend_reg (newest wins).
REQ-029 PEND, stall=0: pc_f <= pend_reg, go RUN; a simultaneous npc_sel!=00 is ignored that cycle.
REQ-030 exc_req or eret_req in PEND SHALL return FSM to RUN.
REQ-031 redir_pending SHALL be 1 exactly while in PEND.
REQ-032 adel_f = (pc_f[1:0]!=0) | (pc_f < IMEM_BASE) | (pc_f >= IMEM_BASE+4*IMEM_WORDS); misaligned targets load unmodified.
REQ-033 Wrap: pc_f = 32'hFFFF_FFFC with sequential advance SHALL yield 32'h0000_0000.

Reset
REQ-034 reset high SHALL immediately force pc_f=RESET_PC, state RUN, pend_reg=0, redir_pending=0, independent of clk.
REQ-035 Reset mid-stall or mid-PEND SHALL discard the buffered redirect; first fetch after release is RESET_PC.

Structure
REQ-036 NPC_SEQ/BR/REG/J encodings and default RESET_PC/EXC_VEC SHALL live in the shared pipeline package/header.
REQ-037 Combinational target calculation SHALL be one sub-module npc_target (npc_sel, imm16, imm26, reg_target, pc4_d -> target); FSM, pc_f and pend_reg in pc_ctrl.

Verification
REQ-038 Release reset, 3 idle cycles -> pc_f 0x3000, 0x3004, 0x3008, 0x300C.
REQ-039 pc4_d=0x3010, npc_sel=01, imm16=0xFFFE, stall=0 -> next pc_f=0x3008.
REQ-040 stall=1 with npc_sel=11, imm26=0x0000C10, pc4_d=0x3004, held 2 cycles -> pc_f frozen, redir_pending=1; stall=0 -> pc_f=0x3040, redir_pending=0.
REQ-041 In PEND, exc_req=1 -> next pc_f=0x4180, redir_pending=0; following eret_req with epc=0x3020 -> pc_f=0x3020.
REQ-042 npc_sel=10, reg_target=0x3002 -> pc_f=0x3002, adel_f=1; reg_target=0x7000 -> adel_f=1.
REQ-043 Assert reset asynchronously mid-PEND between edges -> pc_f=0x3000 before next edge, redir_pending=0.
